// File: rtl/time_setter.sv
// Time-of-day setting controller: two debounced active-low buttons drive an
// hour/minute editor whose result is handed to the clock through a valid/ack load.
module time_setter #(
    parameter int unsigned CLK_HZ          = 50_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic [16:0] cur_seconds,
    input  logic        load_ack,
    output logic        load_valid,
    output logic [16:0] load_value,
    output logic        edit_active,
    output logic [4:0]  edit_hour,
    output logic [5:0]  edit_min,
    output logic [1:0]  blink
);

    localparam int unsigned DB_MAX     = (DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES : 1;
    localparam int unsigned DB_W       = $clog2(DB_MAX + 1);
    localparam int unsigned BLINK_HALF = (CLK_HZ / 4 > 0) ? CLK_HZ / 4 : 1;
    localparam int unsigned BL_W       = $clog2(BLINK_HALF + 1);

    typedef enum logic [1:0] {IDLE, SET_HOUR, SET_MIN, COMMIT} state_t;

    // Button index 0 is mode, index 1 is inc.
    logic [1:0]           btn_raw;
    logic [1:0]           sync1_q, sync2_q;
    logic [1:0]           level_q;
    logic [1:0]           press_q;
    logic [1:0][DB_W-1:0] db_cnt_q;
    logic                 mode_p, inc_p;

    state_t               state_q, state_d;
    logic [4:0]           hour_d;
    logic [5:0]           min_d;
    logic                 lv_d;
    logic [16:0]          lval_d;
    logic                 editing_d;
    logic [BL_W-1:0]      blink_cnt_q, blink_cnt_d;
    logic                 phase_q, phase_d;
    logic [1:0]           blink_d;
    logic [4:0]           cur_hour;
    logic [5:0]           cur_min;

    assign btn_raw  = {btn_inc, btn_mode};
    assign mode_p   = press_q[0];
    assign inc_p    = press_q[1];
    assign cur_hour = 5'(cur_seconds / 17'd3600);
    assign cur_min  = 6'((cur_seconds / 17'd60) % 17'd60);

    // Two-flop synchronizer; idles at the released level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: accept a new level after DB_MAX consecutive differing samples; pulse on press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_q  <= '1;
            press_q  <= '0;
            db_cnt_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                press_q[i] <= 1'b0;
                if (sync2_q[i] == level_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_W'(DB_MAX - 1)) begin
                    db_cnt_q[i] <= '0;
                    level_q[i]  <= sync2_q[i];
                    press_q[i]  <= ~sync2_q[i];
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Next-state, edit values, load handshake and blink phase.
    always_comb begin
        state_d     = state_q;
        hour_d      = edit_hour;
        min_d       = edit_min;
        lv_d        = load_valid;
        lval_d      = load_value;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;

        case (state_q)
            IDLE: begin
                if (mode_p) begin
                    state_d = SET_HOUR;
                    hour_d  = cur_hour;
                    min_d   = cur_min;
                end
            end
            SET_HOUR: begin
                if (mode_p) begin
                    state_d = SET_MIN;
                end else if (inc_p) begin
                    hour_d = (edit_hour == 5'd23) ? 5'd0 : edit_hour + 5'd1;
                end
            end
            SET_MIN: begin
                if (mode_p) begin
                    state_d = COMMIT;
                end else if (inc_p) begin
                    min_d = (edit_min == 6'd59) ? 6'd0 : edit_min + 6'd1;
                end
            end
            COMMIT: begin
                if (!load_valid) begin
                    lv_d   = 1'b1;
                    lval_d = 17'(edit_hour) * 17'd3600 + 17'(edit_min) * 17'd60;
                end else if (load_ack) begin
                    lv_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        editing_d = (state_d == SET_HOUR) || (state_d == SET_MIN);

        // Any press restarts the phase so the edited field shows at once.
        if (mode_p || inc_p || !editing_d) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == BL_W'(BLINK_HALF - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BL_W'(1);
        end

        blink_d = {phase_d & (state_d == SET_HOUR), phase_d & (state_d == SET_MIN)};
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            edit_hour   <= '0;
            edit_min    <= '0;
            load_valid  <= 1'b0;
            load_value  <= '0;
            edit_active <= 1'b0;
            blink       <= 2'b00;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            edit_hour   <= hour_d;
            edit_min    <= min_d;
            load_valid  <= lv_d;
            load_value  <= lval_d;
            edit_active <= editing_d;
            blink       <= blink_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

endmodule

// File: tb/tb_time_setter.sv
// Bench for time_setter: directed scenarios plus random button/ack traffic,
// every cycle compared against a behavioural model of the setter.
module tb_time_setter;

    localparam int CLK_HZ = 16;
    localparam int DB     = 4;
    localparam int HALF   = CLK_HZ / 4;

    localparam int M_IDLE   = 0;
    localparam int M_HOUR   = 1;
    localparam int M_MIN    = 2;
    localparam int M_COMMIT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_mode, btn_inc;
    logic [16:0] cur_seconds;
    logic        load_ack;
    logic        load_valid;
    logic [16:0] load_value;
    logic        edit_active;
    logic [4:0]  edit_hour;
    logic [5:0]  edit_min;
    logic [1:0]  blink;

    int n_cmp = 0;
    int n_bad = 0;

    time_setter #(.CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .cur_seconds(cur_seconds), .load_ack(load_ack), .load_valid(load_valid),
        .load_value(load_value), .edit_active(edit_active), .edit_hour(edit_hour),
        .edit_min(edit_min), .blink(blink)
    );

    always #5 clk = ~clk;

    // Model state.
    int m_state, m_hour, m_min, m_lv, m_lval, m_since;
    bit m_press [2];
    bit m_pipe0 [2];
    bit m_pipe1 [2];
    bit m_level [2];
    bit m_last  [2];
    int m_run   [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expected);
        n_cmp++;
        if (obs !== expected) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE; m_hour = 0; m_min = 0; m_lv = 0; m_lval = 0; m_since = 0;
        for (int i = 0; i < 2; i++) begin
            m_press[i] = 1'b0; m_pipe0[i] = 1'b1; m_pipe1[i] = 1'b1;
            m_level[i] = 1'b1; m_last[i] = 1'b1; m_run[i] = 0;
        end
    endtask

    task automatic model_step();
        bit mp;
        bit ip;
        bit raw;
        bit seen;
        mp = m_press[0];
        ip = m_press[1];
        case (m_state)
            M_IDLE: if (mp) begin
                m_state = M_HOUR;
                m_hour  = int'(cur_seconds) / 3600;
                m_min   = (int'(cur_seconds) / 60) % 60;
            end
            M_HOUR: if (mp) m_state = M_MIN; else if (ip) m_hour = (m_hour + 1) % 24;
            M_MIN:  if (mp) m_state = M_COMMIT; else if (ip) m_min = (m_min + 1) % 60;
            default: begin
                if (m_lv == 0) begin
                    m_lv = 1; m_lval = m_hour * 3600 + m_min * 60;
                end else if (load_ack) begin
                    m_lv = 0; m_state = M_IDLE;
                end
            end
        endcase
        if (mp || ip || !(m_state == M_HOUR || m_state == M_MIN)) m_since = 0;
        else m_since++;
        // A button's value reaches the debouncer two edges after it is sampled; the
        // debounced level follows once the same value has been seen DB times in a row.
        for (int i = 0; i < 2; i++) begin
            raw  = (i == 0) ? btn_mode : btn_inc;
            seen = m_pipe1[i];
            m_pipe1[i] = m_pipe0[i];
            m_pipe0[i] = raw;
            m_run[i]   = (seen == m_last[i]) ? m_run[i] + 1 : 1;
            m_last[i]  = seen;
            m_press[i] = 1'b0;
            if (seen != m_level[i] && m_run[i] >= DB) begin
                m_level[i] = seen;
                m_press[i] = !seen;
            end
        end
    endtask

    // Model advances on the same edges as the design.
    always @(posedge clk or negedge reset) begin
        if (!reset) model_reset();
        else model_step();
    end

    task automatic compare_all();
        logic       ph;
        logic [1:0] exp_blink;
        ph = ((m_since / HALF) % 2) != 0;
        exp_blink = {(m_state == M_HOUR) && ph, (m_state == M_MIN) && ph};
        check("load_valid",  32'(load_valid),  32'(m_lv));
        check("load_value",  32'(load_value),  32'(m_lval));
        check("edit_active", 32'(edit_active), 32'(m_state == M_HOUR || m_state == M_MIN));
        check("edit_hour",   32'(edit_hour),   32'(m_hour));
        check("edit_min",    32'(edit_min),    32'(m_min));
        check("blink",       32'(blink),       32'(exp_blink));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic press(input bit do_mode, input bit do_inc);
        if (do_mode) btn_mode = 1'b0;
        if (do_inc)  btn_inc  = 1'b0;
        cycles(8);
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        cycles(8);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_load_valid"},  32'(load_valid),  32'd0);
        check({tag, "_load_value"},  32'(load_value),  32'd0);
        check({tag, "_edit_active"}, 32'(edit_active), 32'd0);
        check({tag, "_edit_hour"},   32'(edit_hour),   32'd0);
        check({tag, "_edit_min"},    32'(edit_min),    32'd0);
        check({tag, "_blink"},       32'(blink),       32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed running, expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind;
        int hold;
        int gap;
        reset = 1'b0; btn_mode = 1'b1; btn_inc = 1'b1; load_ack = 1'b0; cur_seconds = '0;
        model_reset();
        cycles(3);
        check_reset_values("reset");
        reset = 1'b1;
        cycles(4);

        // Bouncing mode button, then a clean hold: exactly one press.
        cur_seconds = 17'd45296;
        for (int i = 0; i < 10; i++) begin
            btn_mode = i[0];
            cycles(2);
        end
        btn_mode = 1'b0;
        cycles(10);
        btn_mode = 1'b1;
        cycles(8);
        check("preload_active", 32'(edit_active), 32'd1);
        check("preload_hour",   32'(edit_hour),   32'd12);
        check("preload_min",    32'(edit_min),    32'd34);

        // Still in hour edit: inc moves the hour, wrapping at 23.
        press(1'b0, 1'b1);
        check("hour_inc", 32'(edit_hour), 32'd13);
        repeat (10) press(1'b0, 1'b1);
        check("hour_23", 32'(edit_hour), 32'd23);
        press(1'b0, 1'b1);
        check("hour_wrap", 32'(edit_hour), 32'd0);

        // Simultaneous mode+inc: mode wins, hour untouched.
        press(1'b1, 1'b1);
        check("simul_hour", 32'(edit_hour), 32'd0);
        check("simul_min",  32'(edit_min),  32'd34);
        press(1'b0, 1'b1);
        check("min_inc", 32'(edit_min), 32'd35);
        repeat (24) press(1'b0, 1'b1);
        check("min_59", 32'(edit_min), 32'd59);
        press(1'b0, 1'b1);
        check("min_wrap", 32'(edit_min), 32'd0);
        press(1'b1, 1'b0);
        check("commit_a_valid", 32'(load_valid), 32'd1);
        check("commit_a_value", 32'(load_value), 32'd0);
        load_ack = 1'b1;
        tick();
        load_ack = 1'b0;
        check("commit_a_ack", 32'(load_valid), 32'd0);
        cycles(3);

        // Maximum value commit with a delayed acknowledge.
        cur_seconds = 17'd86399;
        press(1'b1, 1'b0);
        check("max_hour", 32'(edit_hour), 32'd23);
        check("max_min",  32'(edit_min),  32'd59);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 32'(load_valid), 32'd1);
            check("hold_value", 32'(load_value), 32'd86340);
            tick();
        end
        load_ack = 1'b1;
        tick();
        load_ack = 1'b0;
        check("max_ack_valid",  32'(load_valid),  32'd0);
        check("max_ack_active", 32'(edit_active), 32'd0);
        press(1'b0, 1'b1);
        check("idle_inc_ignored", 32'(edit_hour), 32'd23);

        // Reset in COMMIT while mode is held down across the reset.
        cur_seconds = 17'd3661;
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        check("pre_reset_valid", 32'(load_valid), 32'd1);
        check("pre_reset_value", 32'(load_value), 32'd3660);
        btn_mode = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("async_reset");
        cycles(3);
        reset = 1'b1;
        cycles(12);
        check("held_press_active", 32'(edit_active), 32'd1);
        check("held_press_hour",   32'(edit_hour),   32'd1);
        check("held_press_valid",  32'(load_valid),  32'd0);
        btn_mode = 1'b1;
        cycles(10);
        press(1'b0, 1'b1);
        check("held_single_pulse", 32'(edit_hour), 32'd2);

        // Random traffic on both buttons, time of day and acknowledge.
        for (int it = 0; it < 80; it++) begin
            kind = $urandom_range(0, 3);
            hold = $urandom_range(1, 10);
            gap  = $urandom_range(3, 12);
            cur_seconds = 17'($urandom_range(0, 86399));
            for (int c = 0; c < hold; c++) begin
                case (kind)
                    0: btn_mode = 1'b0;
                    1: btn_inc  = 1'b0;
                    2: begin btn_mode = 1'b0; btn_inc = 1'b0; end
                    default: btn_mode = 1'($urandom_range(0, 1));
                endcase
                load_ack = 1'($urandom_range(0, 1));
                tick();
            end
            btn_mode = 1'b1;
            btn_inc  = 1'b1;
            for (int c = 0; c < gap; c++) begin
                load_ack = 1'($urandom_range(0, 1));
                tick();
            end
        end
        load_ack = 1'b0;
        cycles(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/time_setter.md
TIME_SETTER -- requirements
Module: time_setter

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500_000, cycles a synchronized button must be stable before it is accepted.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port btn_mode  input  1  raw push button, active-low (pressed = 0), asynchronous to clk.
REQ-006 SHALL have port btn_inc  input  1  raw push button, active-low, asynchronous to clk.
REQ-007 SHALL have port cur_seconds  input  17  current seconds-of-day from the clock, range 0..86_399.
REQ-008 SHALL have port load_ack  input  1  clock consumer accepts load_value this cycle.
REQ-009 SHALL have port load_valid  output  1  load_value is valid; held until acknowledged.
REQ-010 SHALL have port load_value  output  17  new seconds-of-day = hour*3600 + min*60.
REQ-011 SHALL have port edit_active  output  1  high in SET_HOUR and SET_MIN.
REQ-012 SHALL have port edit_hour  output  5  hour being edited, 0..23.
REQ-013 SHALL have port edit_min  output  6  minute being edited, 0..59.
REQ-014 SHALL have port blink  output  2  blank-enable per field: bit1 hour, bit0 minute.

Function
REQ-015 SHALL pass each button through a 2-flop synchronizer before any other use.
REQ-016 SHALL change a debounced level only after its synchronized input has been stable at the new value for DEBOUNCE_CYCLES consecutive cycles; any change restarts the count.
REQ-017 SHALL generate a one-cycle press pulse on each debounced 1->0 transition; release generates no pulse.
REQ-018 SHALL implement states IDLE, SET_HOUR, SET_MIN, COMMIT.
REQ-019 IDLE + mode press -> SET_HOUR; edit_hour <= cur_seconds/3600, edit_min <= (cur_seconds/60)%60, captured in the same cycle.
REQ-020 SET_HOUR + inc press -> edit_hour+1, 23 wraps to 0; mode press -> SET_MIN.
REQ-021 SET_MIN + inc press -> edit_min+1, 59 wraps to 0; mode press -> COMMIT.
REQ-022 SHALL assert load_valid in the cycle after entering COMMIT, with load_value stable, and keep both unchanged until the cycle load_ack=1.
REQ-023 COMMIT with load_valid=1 and load_ack=1 -> IDLE; load_valid SHALL be 0 the following cycle.
REQ-024 load_ack while load_valid=0 SHALL be ignored.
REQ-025 SHALL ignore inc presses in IDLE and COMMIT, and mode presses in COMMIT.
REQ-026 Mode and inc press pulses in the same cycle: mode SHALL act, inc SHALL be discarded.
REQ-027 blink toggle phase SHALL invert every CLK_HZ/4 cycles (2 Hz blink) while edit_active; the phase counter SHALL clear on every press pulse, so the edited field is shown immediately after a press.
REQ-028 blink[1] SHALL equal the phase in SET_HOUR and blink[0] the phase in SET_MIN; all other blink bits SHALL be 0, and blink SHALL be 2'b00 in IDLE and COMMIT.
REQ-029 load_value SHALL be computed at full 17-bit width with no truncation; maximum 23*3600 + 59*60 = 86_340.

Reset
REQ-030 reset=0 SHALL immediately force state IDLE, load_valid=0, load_value=0, edit_active=0, edit_hour=0, edit_min=0, blink=2'b00, debounced levels=1 (released), and all counters=0.
REQ-031 Reset asserted during COMMIT SHALL drop load_valid without waiting for load_ack; no partial value SHALL be delivered after release.
REQ-032 After reset is released, a button already held low SHALL produce exactly one press pulse once the debounce count completes.

Verification (DEBOUNCE_CYCLES=4, CLK_HZ=16)
REQ-033 Bounce: btn_mode toggles every 2 cycles for 20 cycles, then held 0 -> exactly one mode pulse; IDLE->SET_HOUR.
REQ-034 Preload: cur_seconds=45_296 (12:34:56), press mode -> edit_hour=12, edit_min=34, edit_active=1.
REQ-035 Wrap: edit_hour=23, press inc -> edit_hour=0; in SET_MIN, edit_min=59, press inc -> edit_min=0.
REQ-036 Commit: hour=23, min=59, press mode twice, load_ack held 0 for 5 cycles -> load_valid=1 and load_value=86_340 steady; set load_ack=1 -> load_valid=0 the next cycle, state IDLE.
REQ-037 Simultaneous: mode and inc pulses in the same cycle while in SET_HOUR -> state SET_MIN, edit_hour unchanged.
REQ-038 Reset in COMMIT: assert reset=0 while load_valid=1 -> load_valid=0 and all outputs at reset values asynchronously, before the next clock edge.
